// File: rtl/imdct_pkg.sv
// imdct_pkg: shared types and constants for the IMDCT twiddle datapath control.
package imdct_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
    localparam int IMDCT_ALU_LAT = 4;
    localparam int IMDCT_ES_W = 5;
    localparam logic MODE_PRE = 1'b0;
    localparam logic MODE_POST = 1'b1;
endpackage

// File: rtl/imdct_delay_line.sv
// imdct_delay_line: {valid, addr} shift register; tap 1 exposes {valid, addr lsb}, plus the final tap.
module imdct_delay_line #(
    parameter int DEPTH = 5,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [1:0]   tap1,
    output logic [W-1:0] tap_last
);
    logic [DEPTH-1:0][W-1:0] sr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sr <= '0;
        else        sr <= {sr[DEPTH-2:0], d};

    assign tap1     = {sr[0][W-1], sr[0][0]};
    assign tap_last = sr[DEPTH-1];
endmodule

// File: rtl/imdct_twiddle_seq.sv
// imdct_twiddle_seq: streams one pre/post twiddle pass through the ALU and writes results back in place.
module imdct_twiddle_seq
    import imdct_pkg::*;
#(
    parameter int N = 64,
    parameter int AW = 6,
    parameter int ALU_LAT = IMDCT_ALU_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  pass_mode,
    input  logic [IMDCT_ES_W-1:0] es_in,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_ren,
    output logic [AW-1:0]         ram_raddr,
    output logic                  rom_ren,
    output logic [AW-1:0]         rom_addr,
    output logic                  alu_mode,
    output logic [IMDCT_ES_W-1:0] alu_es,
    output logic                  alu_a0,
    output logic                  ram_wen,
    output logic [AW-1:0]         ram_waddr
);
    localparam logic [AW:0]   LAST_RD = (AW+1)'(N - 1);
    localparam logic [AW-1:0] LAST_WR = AW'(N - 1);

    seq_state_t  state, state_nx;
    logic [AW:0] cnt;
    logic [AW:0] dl_last;
    logic [1:0]  dl_t1;
    logic        accept;

    assign accept = state == IDLE && start;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = cnt == LAST_RD ? DRAIN : RUN;
            DRAIN:   state_nx = ram_wen && ram_waddr == LAST_WR ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = state != IDLE;
        done    = state == DONE;
        ram_ren = state == RUN;
    end

    // Counter is one bit wider than the address so N = 2^AW terminates without aliasing.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)            cnt <= '0;
        else if (accept)       cnt <= '0;
        else if (state == RUN) cnt <= cnt + (AW+1)'(1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alu_mode <= 1'b0;
            alu_es   <= '0;
        end else if (accept) begin
            alu_mode <= pass_mode;
            alu_es   <= es_in;
        end

    assign ram_raddr = ram_ren ? cnt[AW-1:0] : '0;
    assign rom_ren   = ram_ren;
    assign rom_addr  = ram_raddr;

    imdct_delay_line #(.DEPTH(1 + ALU_LAT), .W(AW + 1)) u_dl (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        ({ram_ren, ram_raddr}),
        .tap1     (dl_t1),
        .tap_last (dl_last)
    );

    assign alu_a0    = dl_t1[1] & dl_t1[0];
    assign ram_wen   = dl_last[AW];
    assign ram_waddr = dl_last[AW-1:0];
endmodule

// File: tb/tb_imdct_twiddle_seq.sv
// tb_imdct_twiddle_seq: directed cycle-by-cycle checks of the twiddle pass sequencer (N=8 and N=64).
module tb_imdct_twiddle_seq;
    import imdct_pkg::*;

    logic clk = 0, rst_n = 0, start8 = 0, start64 = 0, pass_mode = 0;
    logic [4:0] es_in = 0;
    int nvec = 0, nbad = 0;

    logic busy8, done8, ren8, romren8, mode8, a08, wen8;
    logic [5:0] raddr8, romaddr8, waddr8;
    logic [4:0] es8;
    logic busy64, done64, ren64, romren64, mode64, a064, wen64;
    logic [5:0] raddr64, romaddr64, waddr64;
    logic [4:0] es64;
    logic [29:0] obs8, obs64;

    always #5 clk = ~clk;

    imdct_twiddle_seq #(.N(8), .AW(6), .ALU_LAT(4)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .pass_mode(pass_mode), .es_in(es_in),
        .busy(busy8), .done(done8), .ram_ren(ren8), .ram_raddr(raddr8), .rom_ren(romren8),
        .rom_addr(romaddr8), .alu_mode(mode8), .alu_es(es8), .alu_a0(a08),
        .ram_wen(wen8), .ram_waddr(waddr8)
    );

    imdct_twiddle_seq #(.N(64), .AW(6), .ALU_LAT(4)) u64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .pass_mode(pass_mode), .es_in(es_in),
        .busy(busy64), .done(done64), .ram_ren(ren64), .ram_raddr(raddr64), .rom_ren(romren64),
        .rom_addr(romaddr64), .alu_mode(mode64), .alu_es(es64), .alu_a0(a064),
        .ram_wen(wen64), .ram_waddr(waddr64)
    );

    // Addresses are only meaningful while their enable is high.
    assign obs8  = {busy8, done8, ren8, romren8, ren8 ? raddr8 : 6'd0, romren8 ? romaddr8 : 6'd0,
                    mode8, es8, a08, wen8, wen8 ? waddr8 : 6'd0};
    assign obs64 = {busy64, done64, ren64, romren64, ren64 ? raddr64 : 6'd0, romren64 ? romaddr64 : 6'd0,
                    mode64, es64, a064, wen64, wen64 ? waddr64 : 6'd0};

    // Expected outputs in cycle c after a start accepted in cycle 0, ALU latency 4.
    function automatic logic [29:0] exp_vec(int n, int c, logic md, logic [4:0] es);
        logic rd, wr, a0;
        rd = c >= 1 && c <= n;
        wr = c >= 6 && c <= n + 5;
        a0 = c >= 2 && c <= n + 1 && (c % 2 == 1);
        return {c >= 1 && c <= n + 6, c == n + 6, rd, rd, rd ? 6'(c - 1) : 6'd0, rd ? 6'(c - 1) : 6'd0,
                md, es, a0, wr, wr ? 6'(c - 6) : 6'd0};
    endfunction

    task automatic test_reset();
        #2;
        nvec++;
        if (obs8 !== 30'd0) begin nbad++; $display("FAIL reset_n8 got %h want 0", obs8); end
        nvec++;
        if (obs64 !== 30'd0) begin nbad++; $display("FAIL reset_n64 got %h want 0", obs64); end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_pre();
        pass_mode = MODE_PRE; es_in = 5'd3; start8 = 1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk); start8 = 0; #1;
            nvec++;
            if (obs8 !== exp_vec(8, c, 1'b0, 5'd3)) begin
                nbad++; $display("FAIL pre c%0d got %h want %h", c, obs8, exp_vec(8, c, 1'b0, 5'd3));
            end
        end
    endtask

    // Called while still in cycle 15 of the previous pass: first cycle a start may be accepted.
    task automatic test_back_to_back();
        pass_mode = MODE_POST; es_in = 5'd17; start8 = 1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk); start8 = 0; #1;
            nvec++;
            if (obs8 !== exp_vec(8, c, 1'b1, 5'd17)) begin
                nbad++; $display("FAIL b2b_post c%0d got %h want %h", c, obs8, exp_vec(8, c, 1'b1, 5'd17));
            end
        end
    endtask

    task automatic test_overlap();
        pass_mode = MODE_PRE; es_in = 5'd12; start8 = 1;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            start8 = c == 3 || c == 14;
            pass_mode = start8 ? MODE_POST : MODE_PRE;
            es_in = start8 ? 5'd31 : 5'd12;
            #1;
            nvec++;
            if (obs8 !== exp_vec(8, c, 1'b0, 5'd12)) begin
                nbad++; $display("FAIL overlap c%0d got %h want %h", c, obs8, exp_vec(8, c, 1'b0, 5'd12));
            end
        end
        start8 = 0;
    endtask

    task automatic test_wrap();
        pass_mode = MODE_POST; es_in = 5'd9; start64 = 1;
        for (int c = 1; c <= 73; c++) begin
            @(negedge clk); start64 = 0; #1;
            nvec++;
            if (obs64 !== exp_vec(64, c, 1'b1, 5'd9)) begin
                nbad++; $display("FAIL wrap64 c%0d got %h want %h", c, obs64, exp_vec(64, c, 1'b1, 5'd9));
            end
        end
    endtask

    task automatic test_reset_mid();
        pass_mode = MODE_POST; es_in = 5'd7; start8 = 1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk); start8 = 0;
        end
        @(negedge clk);
        rst_n = 0; #1;
        nvec++;
        if (obs8 !== 30'd0) begin nbad++; $display("FAIL rst_mid_now got %h want 0", obs8); end
        for (int c = 6; c <= 18; c++) begin
            @(negedge clk);
            if (c == 6) rst_n = 1;
            #1;
            nvec++;
            if (obs8 !== 30'd0) begin nbad++; $display("FAIL rst_mid_after c%0d got %h want 0", c, obs8); end
        end
    endtask

    initial begin
        test_reset();
        test_pre();
        test_back_to_back();
        test_overlap();
        test_wrap();
        test_reset_mid();
        test_pre();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/imdct_twiddle_seq.md
# imdct_twiddle_seq

Pass sequencer driving the IMDCT twiddle ALU: on `start` it streams one complete pre-twiddle or post-twiddle pass through the ALU. It issues the data RAM and twiddle ROM reads, presents `mode`, `es` and the odd-index flag aligned with the returning data, and writes the ALU results back in place after the fixed pipeline latency. It sits between the IMDCT top-level control FSM (`start`/`done`) and the data RAM, twiddle ROM and ALU.

## Interface
Parameters:
- `N`, 64: complex pairs per pass; range 2..2^AW.
- `AW`, 6: RAM/ROM address width.
- `ALU_LAT`, 4: cycles from ALU input (`ar`/`ai`/ROM data) to registered result (`z1_d`/`z2_d`).

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pass request; ignored while `busy`.
- `pass_mode`  in  1  0 = pre-twiddle, 1 = post-twiddle; sampled with `start`.
- `es_in`  in  5  block exponent; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle pulse after the last write.
- `ram_ren`  out  1  data RAM read enable.
- `ram_raddr`  out  AW  data RAM read address (pair index k).
- `rom_ren`  out  1  twiddle ROM read enable; equals `ram_ren`.
- `rom_addr`  out  AW  twiddle ROM address; equals `ram_raddr`.
- `alu_mode`  out  1  ALU mode; latched `pass_mode`.
- `alu_es`  out  5  ALU exponent; latched `es_in`.
- `alu_a0`  out  1  bit 0 of the address whose data is currently at the ALU input.
- `ram_wen`  out  1  write enable for `{z1_d, z2_d}`.
- `ram_waddr`  out  AW  write address.

## Operation
- FSM states:
  - IDLE: `start` latches `pass_mode`/`es_in` and moves to RUN.
  - RUN: issues one read per cycle for k = 0..N-1, then moves to DRAIN.
  - DRAIN: waits until the final write has issued, then moves to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Read counter: AW+1 bits; it increments only in RUN. At N = 2^AW the counter wraps the address to 0, which must not create an extra read.
- Delay line: depth 1+ALU_LAT, carrying valid + address.
  - Entry at `ram_ren` / `ram_raddr`.
  - Tap 1 (the RAM/ROM synchronous read latency) feeds `alu_a0`.
  - The final tap feeds `ram_wen` / `ram_waddr`.
- Write-back is in place: result k is written at address k.
- `alu_mode` and `alu_es` change only on an accepted `start`. They hold through RUN, DRAIN and DONE, and until the next accepted `start`.
- `start` during `busy` is ignored. It is not queued and `done` count is unaffected.
- `start` in the DONE cycle is also ignored.
- Reset (async, any state) clears every output: `busy`, `done`, `ram_ren`, `rom_ren`, `ram_wen`, `alu_a0`, `alu_mode` = 0; all addresses = 0; `alu_es` = 0. Reset also clears the delay line, so an in-flight pass produces no further writes.

## Timing
- Accepted `start` at cycle 0.
- Reads: `busy` = 1 from cycle 1; `ram_ren`/`rom_ren` high in cycles 1..N with address k in cycle k+1.
- ALU input: data for k arrives in cycle k+2, with `alu_a0` = k[0] in that same cycle.
- Writes: `ram_wen` with `ram_waddr` = k in cycle k+2+ALU_LAT; the last write is in cycle N+1+ALU_LAT.
- Completion: `done` is in cycle N+2+ALU_LAT; `busy` falls after it.
- Throughput: one pair per clock in steady state. The earliest next accepted `start` is cycle N+3+ALU_LAT.
- Read/write overlap: reads of k and writes of j < k overlap freely. No hazard exists because each address is read once before it is written.

## Structure
- Shared package `imdct_pkg`:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - `IMDCT_ALU_LAT` = 4.
  - `IMDCT_ES_W` = 5.
  - Mode constants `MODE_PRE` = 0, `MODE_POST` = 1.
- Sub-module `imdct_delay_line`: parameterised depth/width shift register with async reset. It carries {valid, addr} and exposes tap 1 and the final tap.

## Test plan
- Pre pass, N = 8, `es_in` = 3:
  - `start` -> reads addresses 0..7 in cycles 1..8.
  - `alu_mode` = 0, `alu_es` = 3.
  - Writes 0..7 in cycles 6..13; `done` in cycle 14.
- Post pass, N = 8:
  - `alu_a0` pattern 0,1,0,1… exactly in cycles 2..9.
  - `alu_mode` = 1 is held through `done`.
- N = 64 = 2^AW wrap:
  - exactly 64 reads and 64 writes; no read at address 0 after address 63.
  - `done` in cycle 70.
- Overlapping requests: `start` repeated at cycles 3 and 14 (N = 8) -> both ignored; a single `done`; `alu_es` unchanged.
- Reset mid-pass: `rst_n` low in cycle 5 -> all outputs 0 immediately; no `ram_wen` afterwards; a new `start` then runs a clean pass.
- Back-to-back passes: `start` in the cycle after `done` -> accepted, with identical timing to the first pass.
